toast_timer_pwm_ch: RTL and testbench

Parametrised successor to the toaster countdown/heater driver. Loads a cook time from the keypad path, counts it down in seconds under an explicit IDLE/RUNNING/PAUSED state machine, and drives a heater PWM whose period and duty width are parameters. Adds pause/resume, a done pulse, time clamping, and glitch-free duty updates at PWM period boundaries. Feeds the 7-segment display path with BCD minutes/tens/ones.

---
 rtl/toast_timer_pwm_ch.sv | 171 +++++++++++++++++
 tb/tb_toast_timer_pwm_ch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toast_timer_pwm_ch.sv
// Toaster cook timer with heater PWM.
// Loads a clamped cook time, counts it down in seconds under an
// IDLE/RUNNING/PAUSED state machine, and drives a heater PWM whose duty
// is only updated at period boundaries or on (re)entry to RUNNING.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   write      load request for time_in (accepted in IDLE only)
//   time_in    cook time in seconds, clamped to MAX_TIME
//   write_ack  one-cycle acknowledge of an accepted write
//   dc_in      heater duty in PWM_PERIOD counts
//   start      start from IDLE, or resume from PAUSED
//   pause      pause while RUNNING
//   stop       abort to IDLE and clear the time
//   pwm        heater drive
//   running    high in RUNNING
//   done       one-cycle pulse when the countdown reaches 0
//   t_disp     {minutes, tens, ones} BCD of the remaining time
module toast_timer_pwm_ch #(
    parameter int unsigned TICKS_PER_SEC = 2000,
    parameter int unsigned PWM_PERIOD    = 256,
    parameter int unsigned DC_W          = 8,
    parameter int unsigned TIME_W        = 10,
    parameter int unsigned MAX_TIME      = 599
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [TIME_W-1:0] time_in,
    output logic              write_ack,
    input  logic [DC_W-1:0]   dc_in,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic              pwm,
    output logic              running,
    output logic              done,
    output logic [11:0]       t_disp
);

    localparam int unsigned SEC_W = $clog2(TICKS_PER_SEC);
    localparam int unsigned PWM_W = $clog2(PWM_PERIOD);
    localparam int unsigned REM_W = (MAX_TIME > 1) ? $clog2(MAX_TIME + 1) : 1;
    localparam int unsigned CMP_W = ((DC_W > PWM_W) ? DC_W : PWM_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [REM_W-1:0]  remaining, remaining_n;
    logic [SEC_W-1:0]  sec_ctr, sec_ctr_n;
    logic [PWM_W-1:0]  pwm_ctr, pwm_ctr_n;
    logic [DC_W-1:0]   dc_q, dc_q_n;
    logic              write_ack_n;
    logic              done_n;

    logic [REM_W-1:0]  load_val;
    logic              sec_wrap;
    logic              pwm_wrap;
    logic [31:0]       rem32;

    // Clamp the requested time so the minutes digit never exceeds 9
    always_comb begin
        if (32'(time_in) > MAX_TIME) begin
            load_val = REM_W'(MAX_TIME);
        end else begin
            load_val = REM_W'(time_in);
        end
    end

    assign sec_wrap = (sec_ctr == SEC_W'(TICKS_PER_SEC - 1));
    assign pwm_wrap = (pwm_ctr == PWM_W'(PWM_PERIOD - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            sec_ctr   <= '0;
            pwm_ctr   <= '0;
            dc_q      <= '0;
            write_ack <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            sec_ctr   <= sec_ctr_n;
            pwm_ctr   <= pwm_ctr_n;
            dc_q      <= dc_q_n;
            write_ack <= write_ack_n;
            done      <= done_n;
        end
    end

    // Next-state: stop beats everything; write only matters in IDLE
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        sec_ctr_n   = sec_ctr;
        pwm_ctr_n   = pwm_ctr;
        dc_q_n      = dc_q;
        write_ack_n = 1'b0;
        done_n      = 1'b0;

        if (stop) begin
            state_n     = S_IDLE;
            remaining_n = '0;
            sec_ctr_n   = '0;
            pwm_ctr_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (write) begin
                        remaining_n = load_val;
                        write_ack_n = 1'b1;
                    end else if (start && (remaining != '0)) begin
                        state_n   = S_RUNNING;
                        sec_ctr_n = '0;
                        pwm_ctr_n = '0;
                        dc_q_n    = dc_in;
                    end
                end
                S_RUNNING: begin
                    if (pause) begin
                        state_n = S_PAUSED;
                    end else begin
                        sec_ctr_n = sec_wrap ? '0 : sec_ctr + SEC_W'(1);
                        pwm_ctr_n = pwm_wrap ? '0 : pwm_ctr + PWM_W'(1);
                        // New duty only takes effect at the period boundary
                        if (pwm_wrap) begin
                            dc_q_n = dc_in;
                        end
                        if (sec_wrap) begin
                            remaining_n = remaining - REM_W'(1);
                            if (remaining == REM_W'(1)) begin
                                state_n = S_IDLE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    // Resume keeps the partial second in sec_ctr
                    if (start) begin
                        state_n = S_RUNNING;
                        dc_q_n  = dc_in;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign running = (state == S_RUNNING);

    // Wide compare so large duties saturate to always-on
    assign pwm = running && (CMP_W'(pwm_ctr) < CMP_W'(dc_q));

    // BCD split of the remaining seconds
    assign rem32  = 32'(remaining);
    assign t_disp = {4'(rem32 / 32'd60),
                     4'((rem32 % 32'd60) / 32'd10),
                     4'((rem32 % 32'd60) % 32'd10)};

endmodule

// File: tb/tb_toast_timer_pwm_ch.sv
// Directed bench for toast_timer_pwm_ch with short second and PWM periods.
module tb_toast_timer_pwm_ch;

    localparam int unsigned TPS    = 4;
    localparam int unsigned PP     = 4;
    localparam int unsigned DC_W   = 8;
    localparam int unsigned TIME_W = 10;

    logic              clk;
    logic              reset;
    logic              write;
    logic [TIME_W-1:0] time_in;
    logic              write_ack;
    logic [DC_W-1:0]   dc_in;
    logic              start;
    logic              pause;
    logic              stop;
    logic              pwm;
    logic              running;
    logic              done;
    logic [11:0]       t_disp;

    int total;
    int bad;
    logic [15:0] pwm_exp;

    toast_timer_pwm_ch #(
        .TICKS_PER_SEC (TPS),
        .PWM_PERIOD    (PP),
        .DC_W          (DC_W),
        .TIME_W        (TIME_W),
        .MAX_TIME      (599)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .time_in   (time_in),
        .write_ack (write_ack),
        .dc_in     (dc_in),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .pwm       (pwm),
        .running   (running),
        .done      (done),
        .t_disp    (t_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        write   = 1'b0;
        time_in = '0;
        dc_in   = '0;
        start   = 1'b0;
        pause   = 1'b0;
        stop    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ack", 32'(write_ack), 0);
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_tdisp", 32'(t_disp), 0);

        // Basic countdown of 3 seconds
        write   = 1'b1;
        time_in = 10'd3;
        tick();
        write = 1'b0;
        chk("t1_ack", 32'(write_ack), 1);
        chk("t1_load", 32'(t_disp), 32'h003);
        start = 1'b1;
        dc_in = 8'd2;
        tick();
        start = 1'b0;
        chk("t1_ack_clr", 32'(write_ack), 0);
        for (int i = 0; i < 12; i++) begin
            chk("t1_running", 32'(running), 1);
            chk("t1_tdisp", 32'(t_disp), 32'(3 - i / 4));
            chk("t1_nodone", 32'(done), 0);
            tick();
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_end_run", 32'(running), 0);
        chk("t1_end_tdisp", 32'(t_disp), 0);
        tick();
        chk("t1_done_clr", 32'(done), 0);

        // PWM patterns and boundary-aligned duty updates
        dc_in   = 8'd2;
        write   = 1'b1;
        time_in = 10'd9;
        tick();
        write = 1'b0;
        start = 1'b1;
        tick();
        start   = 1'b0;
        pwm_exp = 16'hF073;
        for (int i = 0; i < 16; i++) begin
            chk("t2_pwm", 32'(pwm), 32'(pwm_exp[i]));
            if (i == 1)  dc_in = 8'd3;
            if (i == 7)  dc_in = 8'd0;
            if (i == 11) dc_in = 8'd9;
            tick();
        end
        chk("t2_tdisp", 32'(t_disp), 32'h005);

        // Stop mid-run, then start with nothing loaded
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_run", 32'(running), 0);
        chk("t5_tdisp", 32'(t_disp), 0);
        chk("t5_nodone", 32'(done), 0);
        chk("t5_pwm", 32'(pwm), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start0", 32'(running), 0);
        tick();
        chk("t5_nodone2", 32'(done), 0);

        // Clamping, display split, and write ignored while running
        write   = 1'b1;
        time_in = 10'd1000;
        tick();
        chk("t3_clamp_ack", 32'(write_ack), 1);
        chk("t3_clamp", 32'(t_disp), 32'h959);
        time_in = 10'd75;
        tick();
        write = 1'b0;
        chk("t3_75", 32'(t_disp), 32'h115);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_run", 32'(running), 1);
        write   = 1'b1;
        time_in = 10'd5;
        tick();
        write = 1'b0;
        chk("t3_run_noack", 32'(write_ack), 0);
        chk("t3_run_nold", 32'(t_disp), 32'h115);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Pause retains the partial second
        dc_in   = 8'd4;
        write   = 1'b1;
        time_in = 10'd2;
        tick();
        write = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t4_p_pwm", 32'(pwm), 0);
            chk("t4_p_run", 32'(running), 0);
            chk("t4_p_tdisp", 32'(t_disp), 32'h002);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_resume", 32'(running), 1);
        chk("t4_pwm_full", 32'(pwm), 1);
        chk("t4_r0", 32'(t_disp), 32'h002);
        tick();
        chk("t4_r1", 32'(t_disp), 32'h002);
        tick();
        chk("t4_r2", 32'(t_disp), 32'h001);
        tick();
        tick();
        tick();
        chk("t4_r5_nodone", 32'(done), 0);
        chk("t4_r5", 32'(t_disp), 32'h001);
        tick();
        chk("t4_done", 32'(done), 1);
        chk("t4_idle", 32'(running), 0);

        // Reset mid-run and same-cycle command priority
        write   = 1'b1;
        time_in = 10'd5;
        tick();
        write = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_run", 32'(running), 0);
        chk("t6_rst_pwm", 32'(pwm), 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_ack", 32'(write_ack), 0);
        chk("t6_rst_tdisp", 32'(t_disp), 0);
        write   = 1'b1;
        start   = 1'b1;
        time_in = 10'd4;
        tick();
        write = 1'b0;
        start = 1'b0;
        chk("t6_ws_ack", 32'(write_ack), 1);
        chk("t6_ws_run", 32'(running), 0);
        chk("t6_ws_tdisp", 32'(t_disp), 32'h004);
        stop    = 1'b1;
        write   = 1'b1;
        time_in = 10'd7;
        tick();
        stop  = 1'b0;
        write = 1'b0;
        chk("t6_sw_ack", 32'(write_ack), 0);
        chk("t6_sw_tdisp", 32'(t_disp), 0);
        chk("t6_sw_run", 32'(running), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
